// File: rtl/frame_feeder.sv
// frame_feeder
//   Assembles controller frames from a host byte stream, buffers them in a
//   circular frame FIFO and presents one frame per console latch on
//   next_frame. When the FIFO is dry on a latch, the all-ones "no buttons"
//   filler is presented instead and the underflow counter advances.
//
// Ports
//   clk, rst          : sole clock; synchronous active-high reset
//   byte_in/valid     : host byte stream; a transfer is valid & byte_ready
//   byte_ready        : registered; low only while the FIFO is full
//   frame_abort       : discard the partial frame (and any same-cycle byte)
//   latch_in          : raw console latch, asynchronous to clk
//   next_frame        : frame the next console latch will load
//   staged            : next_frame holds a host frame, not the filler
//   fifo_level        : frames waiting in the FIFO (staged frame excluded)
//   underflow_count   : latches serviced with the filler, saturating
module frame_feeder #(
    parameter int FRAME_WIDTH = 16,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     frame_abort,
    input  logic                     latch_in,
    output logic [FRAME_WIDTH-1:0]   next_frame,
    output logic                     staged,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              underflow_count
);
    localparam int BYTES = FRAME_WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [CW-1:0] LAST_BYTE  = CW'(BYTES - 1);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [FRAME_WIDTH-1:0] asm_q, asm_d, asm_merged;
    logic                   s1_q, s2_q, s3_q;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          fifo_level_q, fifo_level_d;
    logic                   byte_ready_q, byte_ready_d;
    logic [FRAME_WIDTH-1:0] next_frame_q, next_frame_d;
    logic                   staged_q, staged_d;
    logic [15:0]            underflow_count_q, underflow_count_d;
    logic [FRAME_WIDTH-1:0] fifo_mem [DEPTH];

    logic xfer, push, pop, latch_ev, fifo_empty;

    assign xfer       = byte_valid & byte_ready_q;
    assign push       = xfer & ~frame_abort & (byte_cnt_q == LAST_BYTE);
    assign latch_ev   = s2_q & ~s3_q;
    assign fifo_empty = (fifo_level_q == '0);

    // ---------------------------------------------------------------
    // Byte assembly: byte k of a frame occupies lane k counted from the
    // MSB, so the first byte's bit 7 is the first bit shifted out.
    // asm_merged is the partial frame with the current byte dropped into
    // its lane; on the last byte it is the completed frame.
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign asm_merged[FRAME_WIDTH-1-8*gi -: 8] =
                (xfer && byte_cnt_q == CW'(gi)) ? byte_in
                                                : asm_q[FRAME_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        if (frame_abort) begin
            // abort wins over a same-cycle byte: that byte is dropped
            byte_cnt_d = '0;
            asm_d      = '0;
        end else if (xfer) begin
            if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = '0;
                asm_d      = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                asm_d      = asm_merged;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output stage. A latch always consumes whatever is staged; the FIFO
    // is checked before this cycle's push, so a frame completing on the
    // latch cycle is only promoted on the following cycle.
    // ---------------------------------------------------------------
    always_comb begin
        pop               = 1'b0;
        next_frame_d      = next_frame_q;
        staged_d          = staged_q;
        underflow_count_d = underflow_count_q;
        if (latch_ev) begin
            if (!fifo_empty) begin
                next_frame_d = fifo_mem[rd_ptr_q];
                staged_d     = 1'b1;
                pop          = 1'b1;
            end else begin
                next_frame_d = '1;
                staged_d     = 1'b0;
                if (underflow_count_q != 16'hFFFF)
                    underflow_count_d = underflow_count_q + 16'd1;
            end
        end else if (!staged_q && !fifo_empty) begin
            next_frame_d = fifo_mem[rd_ptr_q];
            staged_d     = 1'b1;
            pop          = 1'b1;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally at DEPTH (power of two).
    // byte_ready is registered from the updated level, so a pop raises
    // it on the very next cycle and a push into the last slot drops it.
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_level_d = fifo_level_q + LW'(push) - LW'(pop);
        byte_ready_d = (fifo_level_d < FULL_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q        <= '0;
            asm_q             <= '0;
            s1_q              <= 1'b0;
            s2_q              <= 1'b0;
            s3_q              <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            fifo_level_q      <= '0;
            byte_ready_q      <= 1'b0;
            next_frame_q      <= '1;
            staged_q          <= 1'b0;
            underflow_count_q <= '0;
        end else begin
            byte_cnt_q        <= byte_cnt_d;
            asm_q             <= asm_d;
            s1_q              <= latch_in;
            s2_q              <= s1_q;
            s3_q              <= s2_q;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            fifo_level_q      <= fifo_level_d;
            byte_ready_q      <= byte_ready_d;
            next_frame_q      <= next_frame_d;
            staged_q          <= staged_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    // Frame storage; contents need no reset since fifo_level gates reads.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= asm_merged;
    end

    assign byte_ready      = byte_ready_q;
    assign next_frame      = next_frame_q;
    assign staged          = staged_q;
    assign fifo_level      = fifo_level_q;
    assign underflow_count = underflow_count_q;

endmodule
